// File: rtl/arb_mux.sv
// Round-robin N-to-1 stream arbiter with a registered output stage.
// Define ARB_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module arb_mux #(
   parameter  int WIDTH = 8,
   parameter  int N     = 4,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_last,
   output logic [SELW-1:0]    out_sel
);

   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_data;
   logic              r_out_last;
   logic [SELW-1:0]   r_out_sel;
   logic [SELW-1:0]   r_ptr;
`ifdef ARB_MUX_PKT_LOCK_EN
   logic              r_lock;
`endif

   logic              w_load;
   logic              w_xfer;
   logic [SELW-1:0]   w_gnt;
   logic              w_gnt_vld;
   logic [SELW:0]     w_pick;

   // Returns {found, index}; scanning offsets high-to-low lets the nearest requester win.
   function automatic logic [SELW:0] f_rr_pick(input logic [N-1:0] v, input logic [SELW-1:0] p);
      logic [SELW:0]   res;
      logic [SELW-1:0] sidx;
      int              idx;
      res = '0;
      for (int k = N; k >= 1; k--) begin
         idx  = (int'(p) + k) % N;
         sidx = idx[SELW-1:0];
         if (v[sidx]) res = {1'b1, sidx};
      end
      return res;
   endfunction

   assign w_load = !r_out_valid || out_ready;
   assign w_pick = f_rr_pick(in_valid, r_ptr);

   always_comb begin
      w_gnt     = w_pick[SELW-1:0];
      w_gnt_vld = w_pick[SELW];
`ifdef ARB_MUX_PKT_LOCK_EN
      if (r_lock) begin
         w_gnt     = r_ptr;
         w_gnt_vld = in_valid[r_ptr];
      end
`endif
   end

   assign w_xfer = w_load && w_gnt_vld && !reset;

   always_comb begin
      in_ready = '0;
      if (w_xfer) in_ready[w_gnt] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_sel   <= '0;
         r_ptr       <= SELW'(N - 1);
`ifdef ARB_MUX_PKT_LOCK_EN
         r_lock      <= 1'b0;
`endif
      end else begin
         if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[int'(w_gnt)*WIDTH +: WIDTH];
            r_out_last  <= in_last[w_gnt];
            r_out_sel   <= w_gnt;
            r_ptr       <= w_gnt;
`ifdef ARB_MUX_PKT_LOCK_EN
            r_lock      <= !in_last[w_gnt];
`endif
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Directed table-driven bench for arb_mux (N=4, WIDTH=8); expectations follow
// ARB_MUX_PKT_LOCK_EN when the bench is built with it.
module tb_arb_mux;

   logic        clk;
   logic        reset;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_sel;

   int n_vec;
   int n_cmp;
   int n_err;

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] data;
      logic [3:0]  last;
      logic        rdy;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [7:0]  e_data;
      logic [1:0]  e_sel;
      logic        e_last;
   } vec_t;

   localparam logic [31:0] DATA = 32'hD3C2B1A0;

   vec_t tbl[16];
   vec_t pkt[6];
   vec_t v;

   arb_mux #(.WIDTH(8), .N(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sel   (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running required done");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drives one cycle: checks in_ready before the edge, registered outputs after it.
   task automatic apply_vec(input vec_t t, input string tag);
      n_vec++;
      in_valid  = t.vld;
      in_data   = t.data;
      in_last   = t.last;
      out_ready = t.rdy;
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(t.e_rdy));
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(t.e_ov));
      chk({tag, ".out_data"},  32'(out_data),  32'(t.e_data));
      chk({tag, ".out_sel"},   32'(out_sel),   32'(t.e_sel));
      chk({tag, ".out_last"},  32'(out_last),  32'(t.e_last));
   endtask

   initial begin
      n_vec = 0; n_cmp = 0; n_err = 0;

      tbl[0]  = '{4'b1111, DATA, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
      tbl[1]  = '{4'b1111, DATA, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1};
      tbl[2]  = '{4'b1111, DATA, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2, 1'b1};
      tbl[3]  = '{4'b1111, DATA, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 1'b1};
      tbl[4]  = '{4'b1111, DATA, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
      tbl[5]  = '{4'b0000, DATA, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0, 1'b1};
      tbl[6]  = '{4'b0100, DATA, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'hC2, 2'd2, 1'b1};
      tbl[7]  = '{4'b0100, DATA, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hC2, 2'd2, 1'b1};
      tbl[8]  = '{4'b0100, DATA, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hC2, 2'd2, 1'b1};
      tbl[9]  = '{4'b0001, DATA, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
      tbl[10] = '{4'b0000, DATA, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0, 1'b1};
      tbl[11] = '{4'b1001, DATA, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 1'b1};
      tbl[12] = '{4'b1001, DATA, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
      tbl[13] = '{4'b0110, DATA, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0, 1'b1};
      tbl[14] = '{4'b0110, DATA, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1};
      tbl[15] = '{4'b0000, DATA, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hB1, 2'd1, 1'b1};

      // ch1 sends a 3-beat packet with a one-cycle gap while ch3 keeps requesting.
      pkt[0] = '{4'b0010, 32'h33001100, 4'b1000, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b0};
`ifdef ARB_MUX_PKT_LOCK_EN
      pkt[1] = '{4'b1000, 32'h33001100, 4'b1000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1, 1'b0};
      pkt[2] = '{4'b1010, 32'h33001200, 4'b1000, 1'b1, 4'b0010, 1'b1, 8'h12, 2'd1, 1'b0};
      pkt[3] = '{4'b1010, 32'h33001300, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h13, 2'd1, 1'b1};
      pkt[4] = '{4'b1010, 32'h33001300, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3, 1'b1};
      pkt[5] = '{4'b0000, 32'h33001300, 4'b1010, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd3, 1'b1};
`else
      pkt[1] = '{4'b1000, 32'h33001100, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3, 1'b1};
      pkt[2] = '{4'b1010, 32'h33001200, 4'b1000, 1'b1, 4'b0010, 1'b1, 8'h12, 2'd1, 1'b0};
      pkt[3] = '{4'b1010, 32'h33001300, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3, 1'b1};
      pkt[4] = '{4'b1010, 32'h33001300, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h13, 2'd1, 1'b1};
      pkt[5] = '{4'b0000, 32'h33001300, 4'b1010, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd1, 1'b1};
`endif

      reset     = 1'b1;
      in_valid  = 4'b1111;
      in_data   = DATA;
      in_last   = 4'b1111;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.in_ready",  32'(in_ready),  32'h0);
      chk("rst.out_valid", 32'(out_valid), 32'h0);
      chk("rst.out_data",  32'(out_data),  32'h0);
      chk("rst.out_sel",   32'(out_sel),   32'h0);
      chk("rst.out_last",  32'(out_last),  32'h0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));
      for (int i = 0; i < 6; i++)  apply_vec(pkt[i], $sformatf("pkt%0d", i));

      // Open a packet on ch2, stall it, then reset asynchronously mid-cycle.
      v = '{4'b0100, DATA, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'hC2, 2'd2, 1'b0};
      apply_vec(v, "mid");
      #2;
      reset = 1'b1;
      #1;
      chk("arst.out_valid", 32'(out_valid), 32'h0);
      chk("arst.out_data",  32'(out_data),  32'h0);
      chk("arst.out_sel",   32'(out_sel),   32'h0);
      chk("arst.in_ready",  32'(in_ready),  32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      v = '{4'b1111, DATA, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
      apply_vec(v, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
